control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multicycle control unit for the 32-bit datapath.
- Sits directly upstream of the register select/encode logic. It drives Gra/Grb/Grc/Rin/Rout/BAout, plus the bus-out, latch-enable, ALU-op and memory strobes for every datapath element.
- Steps fetch (T0–T2) and one of five execute sequences, decoded from IR[31:27].
- Waits on a memory-ready handshake.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ALUW, 4, alu_op width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ir  in  32  current instruction register contents.
- mem_ready  in  1  memory completed the current Read/Write this cycle.
- Gra, Grb, Grc  out  1 each  register-field select (Ra/Rb/Rc).
- Rin, Rout, BAout  out  1 each  selected-register in / out / base-address out.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout  out  1 each  datapath strobes.
- Read, Write  out  1 each  memory strobes.
- alu_op  out  ALUW  ALU function: ADD=0, SUB=1, AND=2, OR=3.
- run  out  1  high unless halted.

Behaviour:
- Moore machine: all outputs decoded combinationally from the state register (plus ir for alu_op). The state register is the only storage.
- Reset (async, reset_n=0): state=IDLE; every strobe 0, alu_op=0, run=1.
  - Reset mid-instruction abandons it; no memory strobe remains asserted.
- IDLE -> T0 unconditionally on the next edge.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Hold in T1 while mem_ready=0.
  - T2: MDRout, IRin.
  - T2 -> T3. Decode uses ir at T3, i.e. the value latched at the end of T2.
- R-type (add 00011, sub 00100, and 00101, or 00110):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=function.
  - T5: Zlowout, Gra, Rin.
  - -> T0. Six cycles total.
- Immediate (addi 01100, andi 01101, ori 01110):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op.
  - T5: Zlowout, Gra, Rin.
  - -> T0.
- ldi 00001: T3: Grb, BAout, Yin. T4: Cout, Zin, ADD. T5: Zlowout, Gra, Rin. -> T0.
- ld 00000:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; hold while mem_ready=0.
  - T7: MDRout, Gra, Rin.
  - -> T0.
- st 00010:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write; hold while mem_ready=0.
  - -> T0.
- nop 11010: T3 no strobes -> T0.
- Any undefined opcode: treated as nop.
- halt 11011: T3 -> HALTED. All strobes 0, run=0. Leaves HALTED only by reset.
- Handshake rules:
  - Read/Write stay asserted continuously for every held cycle.
  - mem_ready sampled only in T1/T6(ld)/T7(st); ignored elsewhere.
  - mem_ready already high on entry means one cycle in that state.
- Invariants, true in every state:
  - At most one of Gra/Grb/Grc is high.
  - At most one bus driver is high: Rout, BAout, PCout, MDRout, Zlowout, Cout.
  - Rin and Rout are never both high.
  - Read and Write are never both high.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_LD … OP_HALT);
  - ALU function codes;
  - state enumeration (IDLE, T0–T7, HALTED) as a 4-bit encoding.
- Sub-module opcode_decode: combinational ir[31:27] -> instruction class (RTYPE, IMM, LDI, LD, ST, NOP, HALT) plus alu_op.

Test Plan:
- Reset then mem_ready tied 1 -> IDLE with all strobes 0 for the first cycle, then T0 strobes (PCout, MARin, IncPC, Zin) on the next cycle.
- ir=0x18918000 (add r1,r2,r3), mem_ready=1 -> exactly 6 cycles T0..T5. Required strobes:
  - T3: Grb+Rout+Yin.
  - T4: Grc+Rout+Zin, alu_op=0.
  - T5: Gra+Rin+Zlowout.
- ld with mem_ready low 3 cycles in T1 and 2 cycles in T6 -> Read+MDRin held 4 and 3 cycles; total 13 cycles; Gra+Rin+MDRout in the final cycle.
- st, mem_ready=0 for 2 cycles in T7 -> Write high 3 consecutive cycles, Read never high during T3–T7.
- ir opcode 11011 -> run falls after T3 and stays 0 for 20 cycles; reset_n pulse -> run=1, IDLE.
- Assert reset_n=0 asynchronously in T6 of ld -> all strobes 0 before the next clock edge; restart at IDLE.
- Throughout all tests, assert the invariants every cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: opcodes, ALU
// function codes, FSM state codes and the decoded instruction class.
package cpu_ctrl_pkg;

  localparam int OP_W  = 5;
  localparam int ALU_W = 4;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_T0     = 4'd1;
  localparam logic [3:0] S_T1     = 4'd2;
  localparam logic [3:0] S_T2     = 4'd3;
  localparam logic [3:0] S_T3     = 4'd4;
  localparam logic [3:0] S_T4     = 4'd5;
  localparam logic [3:0] S_T5     = 4'd6;
  localparam logic [3:0] S_T6     = 4'd7;
  localparam logic [3:0] S_T7     = 4'd8;
  localparam logic [3:0] S_HALTED = 4'd9;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_IMM   = 3'd1,
    CLS_LDI   = 3'd2,
    CLS_LD    = 3'd3,
    CLS_ST    = 3'd4,
    CLS_NOP   = 3'd5,
    CLS_HALT  = 3'd6
  } instr_class_e;

endpackage

// File: rtl/control_sequencer_opcode_decode.sv
// Combinational opcode decode: IR[31:27] -> instruction class and ALU function.
// Unlisted opcodes fall through to the nop class.
module opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  output instr_class_e     instr_class,
  output logic [ALU_W-1:0] alu_fn
);

  // Class and ALU function per opcode; address arithmetic uses ADD
  always_comb begin
    instr_class = CLS_NOP;
    alu_fn      = ALU_ADD;
    case (opcode)
      OP_ADD:  begin instr_class = CLS_RTYPE; alu_fn = ALU_ADD; end
      OP_SUB:  begin instr_class = CLS_RTYPE; alu_fn = ALU_SUB; end
      OP_AND:  begin instr_class = CLS_RTYPE; alu_fn = ALU_AND; end
      OP_OR:   begin instr_class = CLS_RTYPE; alu_fn = ALU_OR;  end
      OP_ADDI: begin instr_class = CLS_IMM;   alu_fn = ALU_ADD; end
      OP_ANDI: begin instr_class = CLS_IMM;   alu_fn = ALU_AND; end
      OP_ORI:  begin instr_class = CLS_IMM;   alu_fn = ALU_OR;  end
      OP_LDI:  begin instr_class = CLS_LDI;   alu_fn = ALU_ADD; end
      OP_LD:   begin instr_class = CLS_LD;    alu_fn = ALU_ADD; end
      OP_ST:   begin instr_class = CLS_ST;    alu_fn = ALU_ADD; end
      OP_HALT: begin instr_class = CLS_HALT;  alu_fn = ALU_ADD; end
      OP_NOP:  begin instr_class = CLS_NOP;   alu_fn = ALU_ADD; end
      default: begin instr_class = CLS_NOP;   alu_fn = ALU_ADD; end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for the 32-bit datapath: fetch T0-T2, then a
// class-specific execute sequence. The state register is the only storage.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Cout,
  output logic            Read,
  output logic            Write,
  output logic [ALUW-1:0] alu_op,
  output logic            run
);

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  instr_class_e     cls_s;
  logic [ALU_W-1:0] alu_fn_s;
  logic             ir_unused_s;

  // The datapath holds IR stable from the end of T2, so decoding it live is safe
  opcode_decode u_decode (
    .opcode      (ir[31 -: OPW]),
    .instr_class (cls_s),
    .alu_fn      (alu_fn_s)
  );

  assign ir_unused_s = ^ir[31-OPW:0];

  // Next-state logic; mem_ready only matters in the memory-wait states
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (cls_s == CLS_HALT) begin
          state_d = S_HALTED;
        end else if (cls_s == CLS_NOP) begin
          state_d = S_T0;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = ((cls_s == CLS_LD) || (cls_s == CLS_ST)) ? S_T6 : S_T0;
      S_T6: begin
        if (cls_s == CLS_LD) begin
          state_d = mem_ready ? S_T7 : S_T6;
        end else if (cls_s == CLS_ST) begin
          state_d = S_T7;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7: begin
        if (cls_s == CLS_ST) begin
          state_d = mem_ready ? S_T0 : S_T7;
        end else begin
          state_d = S_T0;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode
  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0;
    Read = 1'b0; Write = 1'b0;
    alu_op = '0;
    run = 1'b1;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if ((cls_s == CLS_RTYPE) || (cls_s == CLS_IMM)) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if ((cls_s == CLS_LDI) || (cls_s == CLS_LD) || (cls_s == CLS_ST)) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else begin
          Yin = 1'b0;
        end
      end
      S_T4: begin
        Zin    = 1'b1;
        alu_op = ALUW'(alu_fn_s);
        if (cls_s == CLS_RTYPE) begin
          Grc = 1'b1; Rout = 1'b1;
        end else begin
          Cout = 1'b1;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if ((cls_s == CLS_LD) || (cls_s == CLS_ST)) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (cls_s == CLS_ST) begin
          Gra = 1'b1; Rout = 1'b1;
        end else begin
          Read = 1'b1;
        end
      end
      S_T7: begin
        if (cls_s == CLS_ST) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_HALTED: run = 1'b0;
      default:  run = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe vectors checked
// against hand-built expectations, plus bus/select invariants every cycle.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] ir = 32'h0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin;
  logic MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write, run;
  logic [3:0] alu_op;

  int errors = 0;
  int checks = 0;

  localparam logic [18:0] GRA   = 19'd1 << 18;
  localparam logic [18:0] GRB   = 19'd1 << 17;
  localparam logic [18:0] GRC   = 19'd1 << 16;
  localparam logic [18:0] RIN   = 19'd1 << 15;
  localparam logic [18:0] ROUT  = 19'd1 << 14;
  localparam logic [18:0] BAOUT = 19'd1 << 13;
  localparam logic [18:0] PCOUT = 19'd1 << 12;
  localparam logic [18:0] PCIN  = 19'd1 << 11;
  localparam logic [18:0] INCPC = 19'd1 << 10;
  localparam logic [18:0] MARIN = 19'd1 << 9;
  localparam logic [18:0] MDRIN = 19'd1 << 8;
  localparam logic [18:0] MDROUT = 19'd1 << 7;
  localparam logic [18:0] IRIN  = 19'd1 << 6;
  localparam logic [18:0] YIN   = 19'd1 << 5;
  localparam logic [18:0] ZIN   = 19'd1 << 4;
  localparam logic [18:0] ZLOW  = 19'd1 << 3;
  localparam logic [18:0] COUT  = 19'd1 << 2;
  localparam logic [18:0] READ  = 19'd1 << 1;
  localparam logic [18:0] WRITE = 19'd1 << 0;
  localparam logic [18:0] NONE  = 19'd0;

  localparam logic [18:0] F0  = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [18:0] F1  = ZLOW | PCIN | READ | MDRIN;
  localparam logic [18:0] F2  = MDROUT | IRIN;
  localparam logic [18:0] RT3 = GRB | ROUT | YIN;
  localparam logic [18:0] RT4 = GRC | ROUT | ZIN;
  localparam logic [18:0] RT5 = ZLOW | GRA | RIN;
  localparam logic [18:0] IT4 = COUT | ZIN;
  localparam logic [18:0] LT3 = GRB | BAOUT | YIN;
  localparam logic [18:0] LT5 = ZLOW | MARIN;
  localparam logic [18:0] LT6 = READ | MDRIN;
  localparam logic [18:0] LT7 = MDROUT | GRA | RIN;
  localparam logic [18:0] ST6 = GRA | ROUT | MDRIN;

  wire [18:0] strb_s = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin,
                        MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write};
  wire [23:0] obs_s = {strb_s, alu_op, run};

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  // Structural invariants sampled every cycle
  always @(negedge clock) begin
    checks++;
    if ($onehot0({Gra, Grb, Grc}) !== 1'b1) begin
      errors++; $display("FAIL inv_gsel: got %b want onehot0", {Gra, Grb, Grc});
    end
    checks++;
    if ($onehot0({Rout, BAout, PCout, MDRout, Zlowout, Cout}) !== 1'b1) begin
      errors++; $display("FAIL inv_bus: got %b want onehot0", {Rout, BAout, PCout, MDRout, Zlowout, Cout});
    end
    checks++;
    if ((Rin & Rout) !== 1'b0) begin
      errors++; $display("FAIL inv_rin_rout: got 1 want 0");
    end
    checks++;
    if ((Read & Write) !== 1'b0) begin
      errors++; $display("FAIL inv_read_write: got 1 want 0");
    end
  end

  task automatic do_reset(input logic [31:0] ir_v);
    @(negedge clock);
    reset_n = 1'b0;
    mem_ready = 1'b1;
    ir = ir_v;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs_s !== {NONE, 4'd0, 1'b1}) begin
      errors++; $display("FAIL reset_held: got %h want %h", obs_s, {NONE, 4'd0, 1'b1});
    end
    @(negedge clock);
    reset_n = 1'b1;
    checks++;
    if (obs_s !== {NONE, 4'd0, 1'b1}) begin
      errors++; $display("FAIL reset_idle: got %h want %h", obs_s, {NONE, 4'd0, 1'b1});
    end
    @(negedge clock);
    checks++;
    if (obs_s !== {F0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL reset_t0: got %h want %h", obs_s, {F0, 4'd0, 1'b1});
    end
  endtask

  task automatic test_add();
    logic [18:0] e [8];
    e = '{NONE, F0, F1, F2, RT3, RT4, RT5, F0};
    do_reset(32'h18918000);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs_s !== {e[i], 4'd0, 1'b1}) begin
        errors++; $display("FAIL add cyc%0d: got %h want %h", i, obs_s, {e[i], 4'd0, 1'b1});
      end
    end
  endtask

  task automatic test_ld();
    logic [18:0] e [15];
    logic        mr [15];
    e  = '{NONE, F0, F1, F1, F1, F1, F2, LT3, IT4, LT5, LT6, LT6, LT6, LT7, F0};
    mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
           1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset(32'h00880010);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clock);
      mem_ready = mr[i];
      checks++;
      if (obs_s !== {e[i], 4'd0, 1'b1}) begin
        errors++; $display("FAIL ld cyc%0d: got %h want %h", i, obs_s, {e[i], 4'd0, 1'b1});
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_st();
    logic [18:0] e [12];
    logic        mr [12];
    e  = '{NONE, F0, F1, F2, LT3, IT4, LT5, ST6, WRITE, WRITE, WRITE, F0};
    mr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset(32'h10880020);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clock);
      mem_ready = mr[i];
      checks++;
      if (obs_s !== {e[i], 4'd0, 1'b1}) begin
        errors++; $display("FAIL st cyc%0d: got %h want %h", i, obs_s, {e[i], 4'd0, 1'b1});
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_alu_table();
    logic [7:0]  top [7];
    logic [18:0] t3 [7];
    logic [18:0] t4 [7];
    logic [3:0]  al [7];
    top = '{8'h20, 8'h28, 8'h30, 8'h60, 8'h68, 8'h70, 8'h08};
    t3  = '{RT3, RT3, RT3, RT3, RT3, RT3, LT3};
    t4  = '{RT4, RT4, RT4, IT4, IT4, IT4, IT4};
    al  = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd2, 4'd3, 4'd0};
    for (int k = 0; k < 7; k++) begin
      do_reset({top[k], 24'h9A3C00});
      repeat (4) @(negedge clock);
      checks++;
      if (obs_s !== {t3[k], 4'd0, 1'b1}) begin
        errors++; $display("FAIL alu%0d_t3: got %h want %h", k, obs_s, {t3[k], 4'd0, 1'b1});
      end
      @(negedge clock);
      checks++;
      if (obs_s !== {t4[k], al[k], 1'b1}) begin
        errors++; $display("FAIL alu%0d_t4: got %h want %h", k, obs_s, {t4[k], al[k], 1'b1});
      end
      @(negedge clock);
      checks++;
      if (obs_s !== {RT5, 4'd0, 1'b1}) begin
        errors++; $display("FAIL alu%0d_t5: got %h want %h", k, obs_s, {RT5, 4'd0, 1'b1});
      end
      @(negedge clock);
      checks++;
      if (obs_s !== {F0, 4'd0, 1'b1}) begin
        errors++; $display("FAIL alu%0d_next: got %h want %h", k, obs_s, {F0, 4'd0, 1'b1});
      end
    end
  endtask

  task automatic test_nop();
    logic [7:0] top [3];
    top = '{8'hD0, 8'h38, 8'hF8};
    for (int k = 0; k < 3; k++) begin
      do_reset({top[k], 24'h000000});
      repeat (4) @(negedge clock);
      checks++;
      if (obs_s !== {NONE, 4'd0, 1'b1}) begin
        errors++; $display("FAIL nop%0d_t3: got %h want %h", k, obs_s, {NONE, 4'd0, 1'b1});
      end
      @(negedge clock);
      checks++;
      if (obs_s !== {F0, 4'd0, 1'b1}) begin
        errors++; $display("FAIL nop%0d_next: got %h want %h", k, obs_s, {F0, 4'd0, 1'b1});
      end
    end
  endtask

  task automatic test_halt();
    do_reset(32'hD8000000);
    repeat (4) @(negedge clock);
    checks++;
    if (obs_s !== {NONE, 4'd0, 1'b1}) begin
      errors++; $display("FAIL halt_t3: got %h want %h", obs_s, {NONE, 4'd0, 1'b1});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      mem_ready = i[0];
      checks++;
      if (obs_s !== {NONE, 4'd0, 1'b0}) begin
        errors++; $display("FAIL halt_cyc%0d: got %h want %h", i, obs_s, {NONE, 4'd0, 1'b0});
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_s !== {NONE, 4'd0, 1'b1}) begin
      errors++; $display("FAIL halt_reset: got %h want %h", obs_s, {NONE, 4'd0, 1'b1});
    end
    @(negedge clock);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    checks++;
    if (obs_s !== {NONE, 4'd0, 1'b1}) begin
      errors++; $display("FAIL halt_idle: got %h want %h", obs_s, {NONE, 4'd0, 1'b1});
    end
    @(negedge clock);
    checks++;
    if (obs_s !== {F0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL halt_restart: got %h want %h", obs_s, {F0, 4'd0, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    do_reset(32'h00880010);
    repeat (7) @(negedge clock);
    mem_ready = 1'b0;
    checks++;
    if (obs_s !== {LT6, 4'd0, 1'b1}) begin
      errors++; $display("FAIL ar_t6: got %h want %h", obs_s, {LT6, 4'd0, 1'b1});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_s !== {NONE, 4'd0, 1'b1}) begin
      errors++; $display("FAIL ar_async: got %h want %h", obs_s, {NONE, 4'd0, 1'b1});
    end
    @(negedge clock);
    checks++;
    if (obs_s !== {NONE, 4'd0, 1'b1}) begin
      errors++; $display("FAIL ar_held: got %h want %h", obs_s, {NONE, 4'd0, 1'b1});
    end
    reset_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (obs_s !== {F0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL ar_restart: got %h want %h", obs_s, {F0, 4'd0, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_st();
    test_alu_table();
    test_nop();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
